// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: serial line, frame config and received-word bundle
// for the UART receive core.
interface uart_rx_core_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  RX_IN;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [5:0]            Prescale;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  DATA_VALID;
   logic                  PAR_ERR;
   logic                  STP_ERR;

   modport master (
      output RX_IN, PAR_EN, PAR_TYP, Prescale,
      input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
   );

   modport slave (
      input  RX_IN, PAR_EN, PAR_TYP, Prescale,
      output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
   );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver with 3-sample majority vote,
// optional parity check and stop-bit check.
module uart_rx_core #(
   parameter int DATA_WIDTH = 8
) (
   input  logic         CLK,
   input  logic         RST,
   uart_rx_core_if.slave bus
);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [5:0]            edge_q, edge_d;
   logic [5:0]            pre_q, pre_d;
   logic                  pen_q, pen_d;
   logic                  ptyp_q, ptyp_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [1:0]            samp_q, samp_d;
   logic                  vote_q, vote_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  dv_q, dv_d;
   logic                  perr_q, perr_d;
   logic                  serr_q, serr_d;

   logic [5:0] half;
   logic       bit_end;
   logic       rx;

   assign rx      = bus.RX_IN;
   assign half    = {1'b0, pre_q[5:1]};
   assign bit_end = (edge_q == pre_q - 6'd1);

   // Next-state: bit timing, majority sampling and frame sequencing
   always_comb begin
      state_d = state_q;
      edge_d  = edge_q;
      pre_d   = pre_q;
      pen_d   = pen_q;
      ptyp_d  = ptyp_q;
      bit_d   = bit_q;
      samp_d  = samp_q;
      vote_d  = vote_q;
      shift_d = shift_q;
      data_d  = data_q;
      dv_d    = 1'b0;
      perr_d  = perr_q;
      serr_d  = serr_q;

      if (state_q != IDLE) begin
         edge_d = bit_end ? 6'd0 : edge_q + 6'd1;
         if (edge_q == half - 6'd1) samp_d[0] = rx;
         if (edge_q == half)        samp_d[1] = rx;
         if (edge_q == half + 6'd1)
            vote_d = (samp_q[0] & samp_q[1]) |
                     (samp_q[0] & rx) |
                     (samp_q[1] & rx);
      end

      unique case (state_q)
         IDLE: begin
            edge_d = 6'd0;
            if (!rx) begin
               state_d = START;
               edge_d  = 6'd1;
               pre_d   = bus.Prescale;
               pen_d   = bus.PAR_EN;
               ptyp_d  = bus.PAR_TYP;
            end
         end
         START: begin
            if (bit_end) begin
               if (!vote_q) begin
                  state_d = DATA;
                  bit_d   = '0;
                  perr_d  = 1'b0;
                  serr_d  = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = {vote_q, shift_q[DATA_WIDTH-1:1]};
               bit_d   = bit_q + BW'(1);
               if (bit_q == LAST) begin
                  bit_d   = '0;
                  state_d = pen_q ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               perr_d  = vote_q != ((^shift_q) ^ ptyp_q);
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               serr_d = ~vote_q;
               if (!perr_q && vote_q) begin
                  data_d = shift_q;
                  dv_d   = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         edge_q  <= '0;
         pre_q   <= '0;
         pen_q   <= 1'b0;
         ptyp_q  <= 1'b0;
         bit_q   <= '0;
         samp_q  <= '0;
         vote_q  <= 1'b0;
         shift_q <= '0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         perr_q  <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         edge_q  <= edge_d;
         pre_q   <= pre_d;
         pen_q   <= pen_d;
         ptyp_q  <= ptyp_d;
         bit_q   <= bit_d;
         samp_q  <= samp_d;
         vote_q  <= vote_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         perr_q  <= perr_d;
         serr_q  <= serr_d;
      end
   end

   assign bus.P_DATA     = data_q;
   assign bus.DATA_VALID = dv_q;
   assign bus.PAR_ERR    = perr_q;
   assign bus.STP_ERR    = serr_q;
endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Receive-side companion of the UART transmitter in the UART block. It takes a serial line oversampled by `Prescale` and locates the start bit. It majority-votes each bit, deserialises `DATA_WIDTH` data bits LSB first, checks optional parity and the stop bit, and presents the byte to the system-side synchronizer with a one-cycle `DATA_VALID` strobe. It runs in the UART clock domain, where `CLK` = `Prescale` × baud rate.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `CLK` input 1: oversampling clock.
- `RST` input 1: reset, asynchronous, active-low.
- `RX_IN` input 1: serial line, idle high. Already synchronous to `CLK`; the synchronizer lives upstream.
- `PAR_EN` input 1: 1 = frame carries a parity bit.
- `PAR_TYP` input 1: 0 = even parity, 1 = odd parity.
- `Prescale` input 6: oversampling ratio. Legal values are 8, 16 and 32; any other value gives undefined behaviour.
- `P_DATA` output `DATA_WIDTH`: last good received word.
- `DATA_VALID` output 1: one-cycle strobe; `P_DATA` is new.
- `PAR_ERR` output 1: parity mismatch on the current or last frame.
- `STP_ERR` output 1: stop bit sampled 0 on the current or last frame.

## Operation
- **Latching:** `PAR_EN`, `PAR_TYP` and `Prescale` are latched on start detection. Changes mid-frame are ignored.
- **Counters:**
  - `edge_cnt` runs 0..P-1 within each bit period (P = latched `Prescale`).
  - `bit_cnt` runs 0..DATA_WIDTH-1 during DATA.
- **Sampling:** `RX_IN` is sampled at edges P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority. The bit is consumed at edge P-1 ("bit end").
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:**
  - `edge_cnt` = 0.
  - When `RX_IN` = 0, that cycle is edge 0 of the start bit. Next cycle: START, `edge_cnt` = 1.
- **START, at bit end:**
  - Voted 0: go to DATA and clear `PAR_ERR` and `STP_ERR`.
  - Voted 1 (glitch): go to IDLE. No output changes.
- **DATA, at each bit end:** shift the voted bit in LSB first, so the first data bit lands in bit 0.
  - After bit DATA_WIDTH-1: go to PARITY if `PAR_EN`=1, else STOP.
- **PARITY, at bit end:**
  - Expected bit = XOR of the data bits (even), or its inverse (odd).
  - `PAR_ERR` ← (voted ≠ expected). Go to STOP.
- **STOP, at bit end:**
  - `STP_ERR` ← (voted bit = 0).
  - If there is no parity error and the stop bit = 1: load `P_DATA` and pulse `DATA_VALID`.
  - Go to IDLE.
- **Frame with errors:** `P_DATA` holds its previous value and `DATA_VALID` stays 0. Error flags hold until the next confirmed start bit.
- **Errored or aborted frames:** never produce `DATA_VALID`. The block resumes start hunting immediately in IDLE.

## Timing
- **Reset:** state IDLE; all counters 0; `P_DATA` = 0; `DATA_VALID`, `PAR_ERR`, `STP_ERR` = 0. Reset mid-frame aborts the frame with no strobe.
- **Frame length:** N = 1 + DATA_WIDTH + PAR_EN + 1 bits. The cycle on which the start bit is detected is cycle 0.
- **Result latency:** `DATA_VALID`, `P_DATA`, `PAR_ERR` and `STP_ERR` update on cycle P×N, one cycle after the stop-bit end.
- **`DATA_VALID`:** high for exactly one cycle per good frame.
- **Back-to-back frames:** the strobe cycle is an IDLE cycle. If `RX_IN` = 0 on that cycle, start detection occurs on it (simultaneous event), with no lost frame.
- **Line stuck low after a stop error:** re-detected as a start bit on the first IDLE cycle.
- **Outputs:** all are registered; no combinational path from `RX_IN` to any output.

## Test plan
- **Good frame:** P=8, `PAR_EN`=1 even, 0xA5 (bits 1,0,1,0,0,1,0,1, parity 0, stop 1) → `DATA_VALID` for one cycle at cycle 88, `P_DATA`=0xA5, both errors 0.
- **Parity error:** P=16, `PAR_EN`=1 odd, 0x3C sent with parity bit 0 → `PAR_ERR`=1 at cycle 176. No strobe; `P_DATA` keeps its previous value.
- **Stop error:** P=32, `PAR_EN`=0, 0xFF with stop bit 0 → `STP_ERR`=1 at cycle 320, no strobe. A next good frame 0x12 clears the error at its start-bit end and strobes 0x12.
- **Glitch rejection:** P=8, `RX_IN` low for 2 cycles then high → return to IDLE at edge 7. No strobe, flags and `P_DATA` unchanged.
- **Noise tolerance:** P=16, a single-cycle inversion at edge 8 of data bit 3 of 0x55 → the 2-of-3 vote recovers the bit and `P_DATA`=0x55.
- **Back-to-back and reset:**
  - Two frames with no idle gap (0x01, then 0x80) → two strobes P×N cycles apart, both words correct.
  - Reset asserted in DATA → outputs 0 and no strobe; the next frame is received correctly.
